clk_toggle_monitor: RTL

Windowed edge counter that sits directly downstream of the multi-path clock test design. It consumes that design's counter-derived output bus and counts rising edges per channel over a programmable window. After the window closes it reads out one count per channel over a valid/ready port. Benches use it to confirm that every clock path through buffers and hierarchy actually toggles its consumer.

---
 rtl/clk_toggle_monitor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/clk_toggle_monitor.sv
// rtl/clk_toggle_monitor.sv - windowed per-channel rising-edge counter with valid/ready readout
// Define CLK_TOGGLE_MONITOR_SYNC_EN to add a two-flop synchronizer ahead of the edge registers.
module clk_toggle_monitor #(
    parameter int NCH   = 6,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   sig_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CH_W-1:0]  rpt_chan,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_last
);

    typedef enum logic [1:0] {IDLE, MEAS, RPT} state_t;

    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NCH - 1);

    state_t           state, state_next;
    logic [NCH-1:0]   s, s_d, edge_det;
    logic [CNT_W-1:0] cnt [NCH];
    logic [CNT_W-1:0] cnt_next [NCH];
    logic [WIN_W-1:0] remaining, remaining_next;
    logic [CH_W-1:0]  idx, idx_next;

    logic             busy_n, valid_n, last_n;
    logic [CH_W-1:0]  chan_n;
    logic [CNT_W-1:0] count_n;

`ifdef CLK_TOGGLE_MONITOR_SYNC_EN
    logic [NCH-1:0] m;

    always_ff @(posedge clk) begin
        if (rst) begin
            m   <= '0;
            s   <= '0;
            s_d <= '0;
        end else begin
            m   <= sig_in;
            s   <= m;
            s_d <= s;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= '0;
            s_d <= '0;
        end else begin
            s   <= sig_in;
            s_d <= s;
        end
    end
`endif

    assign edge_det = s & ~s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            idx       <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            idx       <= idx_next;
            for (int i = 0; i < NCH; i++) cnt[i] <= cnt_next[i];
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        idx_next       = idx;
        for (int i = 0; i < NCH; i++) cnt_next[i] = cnt[i];
        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = MEAS;
                    remaining_next = (win_len == '0) ? WIN_W'(1) : win_len;
                    idx_next       = '0;
                    for (int i = 0; i < NCH; i++) cnt_next[i] = '0;
                end
            end
            MEAS: begin
                for (int i = 0; i < NCH; i++) begin
                    if (edge_det[i] && (cnt[i] != '1)) cnt_next[i] = cnt[i] + 1'b1;
                end
                remaining_next = remaining - 1'b1;
                if (remaining == WIN_W'(1)) begin
                    state_next = RPT;
                    idx_next   = '0;
                end
            end
            RPT: begin
                if (rpt_ready) begin
                    if (idx == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from next-state values so the registered copies line up with state.
    always_comb begin
        busy_n  = (state_next != IDLE);
        valid_n = (state_next == RPT);
        chan_n  = valid_n ? idx_next : '0;
        count_n = valid_n ? cnt_next[idx_next] : '0;
        last_n  = valid_n && (idx_next == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            rpt_valid <= 1'b0;
            rpt_chan  <= '0;
            rpt_count <= '0;
            rpt_last  <= 1'b0;
        end else begin
            busy      <= busy_n;
            rpt_valid <= valid_n;
            rpt_chan  <= chan_n;
            rpt_count <= count_n;
            rpt_last  <= last_n;
        end
    end

endmodule
